approx_adder_err_monitor: RTL and testbench

//  Sequential harness that sits around a combinational approximate adder (2+2 bit -> 3 bit) for on-chip error checks.
//  On start it sweeps every input vector into the adder.
//  It captures the adder result and compares it against the exact sum.
//  It accumulates worst-case error, erroneous-vector count and summed absolute error, then flags pass/fail against ET.

---
 rtl/approx_adder_err_monitor.sv | 154 +++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// rtl/approx_adder_err_monitor.sv - exhaustive error sweep around a combinational approximate adder
// Optional first-failure capture (ff_valid/ff_vec/ff_approx) is enabled by defining ERRMON_FIRST_FAIL_EN.
module approx_adder_err_monitor #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int ET    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [2*IN_W-1:0]       vec_o,
  input  logic [OUT_W-1:0]        approx_i,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        max_err,
  output logic [2*IN_W:0]         err_cnt,
  output logic [OUT_W+2*IN_W-1:0] sum_err,
  output logic                    pass
`ifdef ERRMON_FIRST_FAIL_EN
  ,
  output logic                    ff_valid,
  output logic [2*IN_W-1:0]       ff_vec,
  output logic [OUT_W-1:0]        ff_approx
`endif
);

  localparam int VW = 2 * IN_W;
  localparam int CW = VW + 1;
  localparam int SW = OUT_W + VW;
  localparam logic [VW-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  state_t            state_q;
  logic [VW-1:0]     vec_q;
  logic              s1_valid_q;
  logic [VW-1:0]     s1_vec_q;
  logic [OUT_W-1:0]  s1_approx_q;
  logic              busy_q;
  logic              done_q;
  logic [OUT_W-1:0]  max_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     sum_q;
  logic              pass_q;

  logic [OUT_W-1:0]  exact_d;
  logic [OUT_W-1:0]  err_d;
  logic [OUT_W-1:0]  max_d;
  logic [CW-1:0]     cnt_d;
  logic [SW-1:0]     sum_d;
  logic              s1_last_d;

`ifdef ERRMON_FIRST_FAIL_EN
  logic              ff_valid_q;
  logic [VW-1:0]     ff_vec_q;
  logic [OUT_W-1:0]  ff_approx_q;
`endif

  // Stage 2: error of the vector captured by stage 1, folded into the running results.
  always_comb begin
    exact_d   = OUT_W'(s1_vec_q[IN_W-1:0]) + OUT_W'(s1_vec_q[VW-1:IN_W]);
    err_d     = (exact_d >= s1_approx_q) ? (exact_d - s1_approx_q) : (s1_approx_q - exact_d);
    max_d     = (err_d > max_q) ? err_d : max_q;
    cnt_d     = cnt_q + CW'(err_d != '0);
    sum_d     = sum_q + SW'(err_d);
    s1_last_d = s1_valid_q && (s1_vec_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_vec_q    <= '0;
      s1_approx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      pass_q      <= 1'b0;
`ifdef ERRMON_FIRST_FAIL_EN
      ff_valid_q  <= 1'b0;
      ff_vec_q    <= '0;
      ff_approx_q <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      if (s1_valid_q) begin
        max_q <= max_d;
        cnt_q <= cnt_d;
        sum_q <= sum_d;
`ifdef ERRMON_FIRST_FAIL_EN
        if (!ff_valid_q && (32'(err_d) > 32'(ET))) begin
          ff_valid_q  <= 1'b1;
          ff_vec_q    <= s1_vec_q;
          ff_approx_q <= s1_approx_q;
        end
`endif
      end
      case (state_q)
        S_IDLE: begin
          // done_q marks the done cycle of the previous sweep; a start there is dropped.
          if (start && !done_q) begin
            state_q <= S_SWEEP;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            max_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            pass_q  <= 1'b0;
`ifdef ERRMON_FIRST_FAIL_EN
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= '0;
            ff_approx_q <= '0;
`endif
          end
        end
        S_SWEEP: begin
          s1_valid_q  <= 1'b1;
          s1_vec_q    <= vec_q;
          s1_approx_q <= approx_i;
          if (vec_q == LAST) state_q <= S_DRAIN;
          else               vec_q   <= vec_q + VW'(1);
        end
        S_DRAIN: begin
          if (s1_last_d) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (32'(max_d) <= 32'(ET));
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_o   = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign max_err = max_q;
  assign err_cnt = cnt_q;
  assign sum_err = sum_q;
  assign pass    = pass_q;
`ifdef ERRMON_FIRST_FAIL_EN
  assign ff_valid  = ff_valid_q;
  assign ff_vec    = ff_vec_q;
  assign ff_approx = ff_approx_q;
`endif

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb/tb_approx_adder_err_monitor.sv - self-checking bench for approx_adder_err_monitor
module tb_approx_adder_err_monitor;
  localparam int IN_W = 2, OUT_W = 3, ET = 4, N = 16;

  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] vec_o;
  logic [2:0] approx_i;
  logic busy, done, pass;
  logic [2:0] max_err;
  logic [4:0] err_cnt;
  logic [6:0] sum_err;
`ifdef ERRMON_FIRST_FAIL_EN
  logic ff_valid;
  logic [3:0] ff_vec;
  logic [2:0] ff_approx;
`endif

  int checks = 0, errors = 0;
  int mode = 0;
  int lut[16];

  always #5 clk = ~clk;

  approx_adder_err_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_o(vec_o), .approx_i(approx_i),
    .busy(busy), .done(done), .max_err(max_err), .err_cnt(err_cnt),
    .sum_err(sum_err), .pass(pass)
`ifdef ERRMON_FIRST_FAIL_EN
    , .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_approx(ff_approx)
`endif
  );

  // Adder models: 0 exact, 1 tied zero, 2 plus-one, 3 random table, other: split-carry approximation.
  function automatic int model_out(int m, int v);
    int a, b;
    a = v % 4;
    b = v / 4;
    case (m)
      0: return a + b;
      1: return 0;
      2: return (a + b + 1) % 8;
      3: return lut[v];
      default: return ((a / 2) * 2 + (b / 2) * 2) | ((a | b) & 1);
    endcase
  endfunction

  assign approx_i = 3'(model_out(mode, int'(vec_o)));

  task automatic set_mode(input int m);
    mode = -1;
    #1;
    mode = m;
    #1;
  endtask

  task automatic ref_model(input int m, output int emax, output int ecnt, output int esum,
                           output int ffv, output int ffa);
    emax = 0; ecnt = 0; esum = 0; ffv = -1; ffa = 0;
    for (int v = 0; v < N; v++) begin
      int ex, ap, e;
      ex = v % 4 + v / 4;
      ap = model_out(m, v);
      e  = (ex > ap) ? ex - ap : ap - ex;
      if (e > emax) emax = e;
      if (e != 0) ecnt++;
      esum += e;
      if (e > ET && ffv < 0) begin ffv = v; ffa = ap; end
    end
  endtask

  // Pulses start and watches 40 edges; returns done timing and count of sequence violations.
  task automatic do_sweep(input bit repulse, output int done_edge, output int n_done, output int seq_bad);
    done_edge = -1; n_done = 0; seq_bad = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int e = 0; e < 40; e++) begin
      if (done === 1'b1) begin
        n_done++;
        if (done_edge < 0) done_edge = e;
        if (repulse) start = 1'b1;
      end
      if (e <= 16) begin
        if (vec_o !== 4'((e > 15) ? 15 : e) || busy !== 1'b1) seq_bad++;
      end else if (e == 17) begin
        if (vec_o !== 4'd0 || busy !== 1'b0) seq_bad++;
      end else if (busy !== 1'b0) seq_bad++;
      if (repulse && busy === 1'b1 && vec_o == 4'd5) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vec_o, busy, done, max_err, err_cnt, sum_err, pass} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vec=%0d busy=%0b done=%0b max=%0d cnt=%0d sum=%0d pass=%0b required all 0",
               vec_o, busy, done, max_err, err_cnt, sum_err, pass);
    end
`ifdef ERRMON_FIRST_FAIL_EN
    checks++;
    if ({ff_valid, ff_vec, ff_approx} !== '0) begin
      errors++;
      $display("FAIL reset_ff: got valid=%0b vec=%0d approx=%0d required 0", ff_valid, ff_vec, ff_approx);
    end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_sweep_modes();
    int modes[$] = '{0, 1, 2, 4, 3, 3, 3, 3};
    foreach (modes[i]) begin
      int de, nd, sb, emax, ecnt, esum, ffv, ffa;
      if (modes[i] == 3)
        for (int v = 0; v < N; v++) lut[v] = int'($urandom_range(0, 7));
      set_mode(modes[i]);
      ref_model(modes[i], emax, ecnt, esum, ffv, ffa);
      do_sweep(1'b0, de, nd, sb);
      checks += 7;
      if (de != 17) begin errors++; $display("FAIL mode%0d done_edge: got %0d required 17", modes[i], de); end
      if (nd != 1) begin errors++; $display("FAIL mode%0d done_count: got %0d required 1", modes[i], nd); end
      if (sb != 0) begin errors++; $display("FAIL mode%0d vec_busy_seq: got %0d violations required 0", modes[i], sb); end
      if (int'(max_err) != emax) begin errors++; $display("FAIL mode%0d max_err: got %0d required %0d", modes[i], max_err, emax); end
      if (int'(err_cnt) != ecnt) begin errors++; $display("FAIL mode%0d err_cnt: got %0d required %0d", modes[i], err_cnt, ecnt); end
      if (int'(sum_err) != esum) begin errors++; $display("FAIL mode%0d sum_err: got %0d required %0d", modes[i], sum_err, esum); end
      if (pass !== (emax <= ET)) begin errors++; $display("FAIL mode%0d pass: got %0b required %0b", modes[i], pass, emax <= ET); end
      if (modes[i] == 1) begin
        checks++;
        if (max_err !== 3'd6 || err_cnt !== 5'd15 || sum_err !== 7'd48 || pass !== 1'b0) begin
          errors++;
          $display("FAIL zero_adder_const: got %0d/%0d/%0d/%0b required 6/15/48/0", max_err, err_cnt, sum_err, pass);
        end
      end
`ifdef ERRMON_FIRST_FAIL_EN
      checks++;
      if (ff_valid !== (ffv >= 0) || (ffv >= 0 && (int'(ff_vec) != ffv || int'(ff_approx) != ffa))) begin
        errors++;
        $display("FAIL mode%0d first_fail: got valid=%0b vec=%0d approx=%0d required valid=%0b vec=%0d approx=%0d",
                 modes[i], ff_valid, ff_vec, ff_approx, ffv >= 0, ffv, ffa);
      end
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (int'(sum_err) != esum || int'(max_err) != emax || busy !== 1'b0) begin
        errors++;
        $display("FAIL mode%0d hold: got sum=%0d max=%0d busy=%0b required %0d %0d 0", modes[i], sum_err, max_err, busy, esum, emax);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int de, nd, sb, guard, late_done;
    set_mode(0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    guard = 0;
    while (vec_o !== 4'd7 && guard < 30) begin @(posedge clk); #1; guard++; end
    checks++;
    if (guard >= 30) begin errors++; $display("FAIL rst_mid_wait: got timeout required vec_o=7"); end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if ({vec_o, busy, done, max_err, err_cnt, sum_err, pass} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got vec=%0d busy=%0b done=%0b max=%0d cnt=%0d sum=%0d required all 0",
               vec_o, busy, done, max_err, err_cnt, sum_err);
    end
    late_done = 0;
    repeat (25) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) late_done++; end
    checks++;
    if (late_done != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles required 0", late_done); end
    do_sweep(1'b0, de, nd, sb);
    checks++;
    if (de != 17 || nd != 1 || sb != 0 || max_err !== 3'd0 || err_cnt !== 5'd0 || sum_err !== 7'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rerun: got edge=%0d dones=%0d bad=%0d max=%0d cnt=%0d sum=%0d pass=%0b required 17 1 0 0 0 0 1",
               de, nd, sb, max_err, err_cnt, sum_err, pass);
    end
  endtask

  task automatic test_back_to_back();
    int de, nd, sb, emax, ecnt, esum, ffv, ffa;
    set_mode(2);
    ref_model(2, emax, ecnt, esum, ffv, ffa);
    do_sweep(1'b1, de, nd, sb);
    checks += 3;
    if (nd != 1) begin errors++; $display("FAIL restart_done_count: got %0d required 1", nd); end
    if (sb != 0 || de != 17) begin errors++; $display("FAIL restart_sequence: got bad=%0d edge=%0d required 0 17", sb, de); end
    if (int'(sum_err) != esum || int'(err_cnt) != ecnt || pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_results: got sum=%0d cnt=%0d pass=%0b required %0d %0d 1", sum_err, err_cnt, pass, esum, ecnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    test_reset();
    test_sweep_modes();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
